// File: rtl/adc_calc_pkg.sv
// rtl/adc_calc_pkg.sv - shared types and constants for the ADC float scaling datapath
package adc_calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE1,
        ST_WAIT1,
        ST_ISSUE2,
        ST_WAIT2,
        ST_DONE
    } state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    localparam int FP_W  = 32;
    localparam int FMA_W = 3 * FP_W;
    localparam int OVR_W = 16;

endpackage

// File: rtl/adc_float_scale_seq_if.sv
// rtl/adc_float_scale_seq_if.sv - operand/result streams to the shared float FMA core
interface adc_float_scale_seq_if;
    import adc_calc_pkg::*;

    logic [FMA_W-1:0] m_fma_tdata;
    logic             m_fma_tvalid;
    logic             m_fma_tready;
    logic [FP_W-1:0]  s_fma_tdata;
    logic             s_fma_tvalid;
    logic             s_fma_tready;

    modport master (
        output m_fma_tdata, m_fma_tvalid, s_fma_tready,
        input  m_fma_tready, s_fma_tdata, s_fma_tvalid
    );

    modport slave (
        input  m_fma_tdata, m_fma_tvalid, s_fma_tready,
        output m_fma_tready, s_fma_tdata, s_fma_tvalid
    );

endinterface

// File: rtl/adc_u2f.sv
// rtl/adc_u2f.sv - exact unsigned code to float32 converter (priority encoder + shifter)
module adc_u2f
    import adc_calc_pkg::*;
#(
    parameter int ADC_W = 24
) (
    input  logic [ADC_W-1:0] code_i,
    output logic [FP_W-1:0]  fp_o
);

    logic [4:0]  msb;
    logic        found;
    logic [23:0] ext;
    logic [23:0] aligned;

    always_comb begin
        msb   = '0;
        found = 1'b0;
        for (int i = 0; i < ADC_W; i++) begin
            if (code_i[i]) begin
                msb   = 5'(i);
                found = 1'b1;
            end
        end
        ext     = 24'(code_i);
        // leading one lands on bit 23 and is dropped as the hidden bit
        aligned = ext << (5'd23 - msb);
        fp_o    = found ? {1'b0, 8'd127 + {3'b000, msb}, aligned[22:0]} : FP_ZERO;
    end

endmodule

// File: rtl/adc_float_scale_seq.sv
// rtl/adc_float_scale_seq.sv - per-channel (code*gain+offset)*factor+factor_offset on a shared FMA
module adc_float_scale_seq
    import adc_calc_pkg::*;
#(
    parameter int NCH     = 7,
    parameter int ADC_W   = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                   s00_axi_aclk,
    input  logic                   s00_axi_aresetn,
    input  logic [NCH*ADC_W-1:0]   i_adc_data,
    input  logic                   i_adc_valid,
    input  logic [NCH*FP_W-1:0]    i_gain,
    input  logic [NCH*FP_W-1:0]    i_offset,
    input  logic [NCH*FP_W-1:0]    i_factor,
    input  logic [NCH*FP_W-1:0]    i_factor_offset,
    adc_float_scale_seq_if.master  fma,
    output logic [NCH*FP_W-1:0]    o_result,
    output logic                   o_result_valid,
    output logic                   o_busy,
    output logic [OVR_W-1:0]       o_overrun_cnt,
    output logic                   o_timeout_err
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t                      state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic [NCH-1:0][ADC_W-1:0]   code_q, code_d;
    logic [NCH-1:0][FP_W-1:0]    gain_q, gain_d, offs_q, offs_d;
    logic [NCH-1:0][FP_W-1:0]    fact_q, fact_d, foff_q, foff_d;
    logic [NCH-1:0][FP_W-1:0]    shadow_q, shadow_d, result_q;
    logic [FP_W-1:0]             p1_q, p1_d, a_cvt;
    logic [FMA_W-1:0]            m_tdata_q, m_tdata_d;
    logic                        m_tvalid_q, result_valid_q, terr_q, terr_d;
    logic [OVR_W-1:0]            ovr_q;
    logic                        issue_fire, result_fire, timed_out, s_ready;

    assign s_ready     = (state_q == ST_WAIT1) || (state_q == ST_WAIT2);
    assign issue_fire  = m_tvalid_q && fma.m_fma_tready;
    assign result_fire = fma.s_fma_tvalid && s_ready;
    assign timed_out   = (state_q inside {ST_ISSUE1, ST_WAIT1, ST_ISSUE2, ST_WAIT2})
                         && (timer_q == TMR_W'(TIMEOUT));

    adc_u2f #(.ADC_W(ADC_W)) u_u2f (
        .code_i (code_d[ch_d]),
        .fp_o   (a_cvt)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        p1_d     = p1_q;
        shadow_d = shadow_q;
        terr_d   = terr_q;
        code_d   = code_q;
        gain_d   = gain_q;
        offs_d   = offs_q;
        fact_d   = fact_q;
        foff_d   = foff_q;
        case (state_q)
            ST_IDLE: begin
                if (i_adc_valid) begin
                    code_d  = i_adc_data;
                    gain_d  = i_gain;
                    offs_d  = i_offset;
                    fact_d  = i_factor;
                    foff_d  = i_factor_offset;
                    ch_d    = '0;
                    state_d = ST_ISSUE1;
                end
            end
            ST_ISSUE1: if (issue_fire) state_d = ST_WAIT1;
            ST_WAIT1: begin
                if (result_fire) begin
                    p1_d    = fma.s_fma_tdata;
                    state_d = ST_ISSUE2;
                end
            end
            ST_ISSUE2: if (issue_fire) state_d = ST_WAIT2;
            ST_WAIT2: begin
                if (result_fire) begin
                    shadow_d[ch_q] = fma.s_fma_tdata;
                    if (ch_q == CH_W'(NCH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = ST_ISSUE1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // a handshake completing on the last allowed cycle still wins over the abort
        if (timed_out && (state_d == state_q)) begin
            state_d = ST_IDLE;
            terr_d  = 1'b1;
        end
        timer_d = ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_DONE))
                  ? '0 : timer_q + 1'b1;
    end

    // operands are built from next-state values so they are registered alongside tvalid
    always_comb begin
        m_tdata_d = m_tdata_q;
        if (state_d == ST_ISSUE1) begin
            m_tdata_d = {offs_d[ch_d], gain_d[ch_d], a_cvt};
        end else if (state_d == ST_ISSUE2) begin
            m_tdata_d = {foff_d[ch_d], fact_d[ch_d], p1_d};
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            timer_q        <= '0;
            code_q         <= '0;
            gain_q         <= '0;
            offs_q         <= '0;
            fact_q         <= '0;
            foff_q         <= '0;
            shadow_q       <= '0;
            result_q       <= {NCH{FP_ZERO}};
            p1_q           <= FP_ZERO;
            m_tdata_q      <= '0;
            m_tvalid_q     <= 1'b0;
            result_valid_q <= 1'b0;
            terr_q         <= 1'b0;
            ovr_q          <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            timer_q        <= timer_d;
            code_q         <= code_d;
            gain_q         <= gain_d;
            offs_q         <= offs_d;
            fact_q         <= fact_d;
            foff_q         <= foff_d;
            shadow_q       <= shadow_d;
            p1_q           <= p1_d;
            m_tdata_q      <= m_tdata_d;
            m_tvalid_q     <= (state_d == ST_ISSUE1) || (state_d == ST_ISSUE2);
            terr_q         <= terr_d;
            result_valid_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                result_q <= shadow_q;
            end
            if (i_adc_valid && (state_q != ST_IDLE) && (ovr_q != '1)) begin
                ovr_q <= ovr_q + 1'b1;
            end
        end
    end

    assign fma.m_fma_tdata  = m_tdata_q;
    assign fma.m_fma_tvalid = m_tvalid_q;
    assign fma.s_fma_tready = s_ready;

    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_overrun_cnt  = ovr_q;
    assign o_timeout_err  = terr_q;

endmodule

// File: tb/tb_adc_float_scale_seq.sv
// tb/tb_adc_float_scale_seq.sv - scoreboard bench with a stalling 5-cycle FMA model
module tb_adc_float_scale_seq;
    import adc_calc_pkg::*;

    localparam int NCH     = 7;
    localparam int ADC_W   = 24;
    localparam int TIMEOUT = 255;
    localparam int LAT     = 5;

    typedef logic [NCH*32-1:0] bank_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH*ADC_W-1:0] adc_data;
    logic                 adc_valid;
    logic [NCH*32-1:0]    gain_bus, off_bus, fac_bus, foff_bus;
    bank_t                o_result;
    logic                 o_result_valid, o_busy, o_timeout_err;
    logic [15:0]          o_overrun_cnt;

    adc_float_scale_seq_if fma_if ();

    adc_float_scale_seq #(.NCH(NCH), .ADC_W(ADC_W), .TIMEOUT(TIMEOUT)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .i_adc_data      (adc_data),
        .i_adc_valid     (adc_valid),
        .i_gain          (gain_bus),
        .i_offset        (off_bus),
        .i_factor        (fac_bus),
        .i_factor_offset (foff_bus),
        .fma             (fma_if),
        .o_result        (o_result),
        .o_result_valid  (o_result_valid),
        .o_busy          (o_busy),
        .o_overrun_cnt   (o_overrun_cnt),
        .o_timeout_err   (o_timeout_err)
    );

    logic [ADC_W-1:0] u2f_code;
    logic [31:0]      u2f_fp;
    adc_u2f #(.ADC_W(ADC_W)) u_u2f_ref (.code_i(u2f_code), .fp_o(u2f_fp));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] mr;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e  = int'(d[62:52]) - 1023 + 127;
        m  = {1'b1, d[51:0]};
        mr = {1'b0, m[52:29]};
        if (m[28] && ((|m[27:0]) || mr[0])) mr = mr + 25'd1;
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        return {d[63], 8'(e), mr[22:0]};
    endfunction

    function automatic logic [31:0] fma_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    logic [NCH-1:0][ADC_W-1:0] st_code;
    logic [NCH-1:0][31:0]      st_gain, st_off, st_fac, st_foff;
    bank_t                     exp_q[$];

    function automatic bank_t model_frame();
        bank_t       e;
        logic [31:0] p1;
        for (int i = 0; i < NCH; i++) begin
            p1 = fma_ref(r2f(real'(st_code[i])), st_gain[i], st_off[i]);
            e[i*32 +: 32] = fma_ref(p1, st_fac[i], st_foff[i]);
        end
        return e;
    endfunction

    // FMA core model: decisions at negedge, transfers happen at the following posedge
    logic [95:0] op, op_pend;
    int          cd;
    bit          pend, m_fire, s_fire, hold_off;
    int          issues = 0;

    initial begin
        fma_if.m_fma_tready = 1'b0;
        fma_if.s_fma_tvalid = 1'b0;
        fma_if.s_fma_tdata  = '0;
        pend = 0; m_fire = 0; s_fire = 0; cd = 0; op = '0; op_pend = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; m_fire = 0; s_fire = 0;
                fma_if.m_fma_tready = 1'b0;
                fma_if.s_fma_tvalid = 1'b0;
                fma_if.s_fma_tdata  = '0;
            end else begin
                if (m_fire) begin
                    op = op_pend;
                    pend = 1;
                    cd = LAT - 1 + $urandom_range(0, 2);
                    issues++;
                end
                if (s_fire) fma_if.s_fma_tvalid = 1'b0;
                if (pend && !fma_if.s_fma_tvalid) begin
                    if (cd == 0) begin
                        fma_if.s_fma_tdata  = fma_ref(op[31:0], op[63:32], op[95:64]);
                        fma_if.s_fma_tvalid = 1'b1;
                        pend = 0;
                    end else begin
                        cd--;
                    end
                end
                fma_if.m_fma_tready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
                m_fire = fma_if.m_fma_tvalid && fma_if.m_fma_tready;
                op_pend = fma_if.m_fma_tdata;
                s_fire = fma_if.s_fma_tvalid && fma_if.s_fma_tready;
            end
        end
    end

    int pulses = 0;
    initial begin
        bank_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_result_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < NCH; i++)
                        chk($sformatf("res_ch%0d", i), o_result[i*32 +: 32], e[i*32 +: 32]);
                end
            end
        end
    end

    task automatic set_cfg(input logic [ADC_W-1:0] code, input logic [31:0] g,
                           input logic [31:0] o, input logic [31:0] f, input logic [31:0] fo);
        for (int i = 0; i < NCH; i++) begin
            st_code[i] = code; st_gain[i] = g; st_off[i] = o; st_fac[i] = f; st_foff[i] = fo;
        end
    endtask

    task automatic send_frame(input bit push);
        adc_data  = st_code;
        gain_bus  = st_gain;
        off_bus   = st_off;
        fac_bus   = st_fac;
        foff_bus  = st_foff;
        adc_valid = 1'b1;
        if (push) exp_q.push_back(model_frame());
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (o_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (o_busy) chk("idle_bound", o_busy, 0);
    endtask

    task automatic run_frame(input string tag);
        int p0, n;
        p0 = pulses;
        send_frame(1);
        wait_idle(2000, n);
        repeat (2) @(negedge clk);
        chk({tag, "_pulses"}, pulses - p0, 1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [23:0] sw_code [4];
        logic [31:0] sw_exp [4];
        bank_t       res_before;
        int          n, p0, base;

        adc_valid = 1'b0; adc_data = '0; hold_off = 0;
        gain_bus = '0; off_bus = '0; fac_bus = '0; foff_bus = '0;

        sw_code = '{24'h000000, 24'h000001, 24'h800000, 24'hFFFFFF};
        sw_exp  = '{32'h00000000, 32'h3F800000, 32'h4B000000, 32'h4B7FFFFF};
        for (int i = 0; i < 4; i++) begin
            u2f_code = sw_code[i];
            #1;
            chk($sformatf("u2f_%0h", sw_code[i]), u2f_fp, sw_exp[i]);
        end

        repeat (3) @(negedge clk);
        chk("rst_result", o_result == '0, 1);
        chk("rst_valid", o_result_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovr", o_overrun_cnt, 0);
        chk("rst_terr", o_timeout_err, 0);
        chk("rst_m_tvalid", fma_if.m_fma_tvalid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_cfg(24'h000000, 32'h35A00000, 32'hC1200000, FP_ONE, FP_ZERO);
        run_frame("code0");
        chk("code0_direct", o_result[31:0], 32'hC1200000);

        set_cfg(24'h800000, 32'h35A00000, 32'hC1200000, FP_ONE, FP_ZERO);
        run_frame("code8m");
        chk("code8m_direct", o_result[NCH*32-1 -: 32], 32'h00000000);

        set_cfg(24'h000000, FP_ONE, FP_ZERO, 32'h40000000, FP_ONE);
        for (int i = 0; i < NCH; i++) st_code[i] = 24'($urandom_range(0, 24'hFFFFFF));
        st_code[0] = 24'hFFFFFF;
        run_frame("mixed");

        set_cfg(24'h800000, 32'h35A00000, 32'hC1200000, 32'h42F42388, 32'h3EBE76C9);
        run_frame("factor");
        for (int i = 0; i < NCH; i++)
            chk($sformatf("factor_slot%0d", i), o_result[i*32 +: 32], 32'h3EBE76C9);

        // overrun: second strobe three cycles after the first, with different constants
        p0 = pulses;
        set_cfg(24'h000000, 32'h35A00000, 32'hC1200000, FP_ONE, FP_ZERO);
        send_frame(1);
        repeat (2) @(negedge clk);
        set_cfg(24'h800000, FP_ONE, FP_ONE, FP_ONE, FP_ONE);
        send_frame(0);
        wait_idle(2000, n);
        repeat (2) @(negedge clk);
        chk("ovr_cnt", o_overrun_cnt, 1);
        chk("ovr_pulses", pulses - p0, 1);
        chk("ovr_sb_empty", exp_q.size(), 0);
        chk("ovr_first_kept", o_result[31:0], 32'hC1200000);

        // timeout: core never accepts operands
        res_before = o_result;
        p0 = pulses;
        hold_off = 1;
        set_cfg(24'h000123, FP_ONE, FP_ONE, FP_ONE, FP_ONE);
        send_frame(0);
        wait_idle(TIMEOUT + 50, n);
        repeat (2) @(negedge clk);
        hold_off = 0;
        chk("tmo_err", o_timeout_err, 1);
        chk("tmo_busy", o_busy, 0);
        chk("tmo_dur", n >= TIMEOUT - 2, 1);
        chk("tmo_no_pulse", pulses - p0, 0);
        chk("tmo_result_kept", o_result == res_before, 1);

        // reset while waiting on the second FMA of channel 3
        set_cfg(24'h000000, 32'h35A00000, 32'hC1200000, FP_ONE, FP_ZERO);
        base = issues;
        send_frame(1);
        n = 0;
        while ((issues - base) < 8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached", (issues - base) >= 8, 1);
        rst_n = 1'b0;
        #1;
        chk("rstm_result", o_result == '0, 1);
        chk("rstm_valid", o_result_valid, 0);
        chk("rstm_busy", o_busy, 0);
        chk("rstm_ovr", o_overrun_cnt, 0);
        chk("rstm_terr", o_timeout_err, 0);
        chk("rstm_m_tvalid", fma_if.m_fma_tvalid, 0);
        chk("rstm_s_tready", fma_if.s_fma_tready, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_cfg(24'h000000, 32'h35A00000, 32'hC1200000, FP_ONE, FP_ZERO);
        st_code[3] = 24'h800000;
        run_frame("post_rst");
        chk("post_rst_ch3", o_result[3*32 +: 32], 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
